// File: rtl/ysyx_22040759_pc_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over valid/ready,
// hands instructions to execute, redirects to mtvec on traps, counts retirements.
module ysyx_22040759_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  input  logic        ifu_rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_pc,
  input  logic        exu_jump,
  input  logic        exu_link,
  input  logic        exu_done,
  output logic        pc_sel,
  output logic        wreg_sel,
  input  logic [31:0] pc_new,
  input  logic [31:0] mtvec,
  output logic        trap_valid,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [63:0] retired
);

  // Shared next-PC / writeback mux select encodings.
  localparam logic SEL_PC_PC    = 1'b0;
  localparam logic SEL_PC_ALU   = 1'b1;
  localparam logic SEL_WREG_ALU = 1'b0;
  localparam logic SEL_WREG_PC  = 1'b1;

  localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
  localparam logic [1:0] CAUSE_FETCH    = 2'd1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_RSP = 3'd2,
    EXEC     = 3'd3,
    TRAP     = 3'd4
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic [1:0]  trap_cause_r;
  logic [31:0] trap_epc_r;
  logic [63:0] retired_r;
  logic        misaligned_s;

  assign misaligned_s = (pc_new[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and mux selects; selects only follow execute inside EXEC.
  always_comb begin
    state_next_s = state_r;
    pc_sel       = SEL_PC_PC;
    wreg_sel     = SEL_WREG_ALU;
    case (state_r)
      IDLE: state_next_s = FETCH;
      FETCH: begin
        if (ifu_req_ready) state_next_s = WAIT_RSP;
        else               state_next_s = FETCH;
      end
      WAIT_RSP: begin
        if (ifu_rsp_valid) state_next_s = ifu_rsp_err ? TRAP : EXEC;
        else               state_next_s = WAIT_RSP;
      end
      EXEC: begin
        pc_sel   = exu_jump ? SEL_PC_ALU : SEL_PC_PC;
        wreg_sel = exu_link ? SEL_WREG_PC : SEL_WREG_ALU;
        if (exu_done) state_next_s = misaligned_s ? TRAP : FETCH;
        else          state_next_s = EXEC;
      end
      TRAP:    state_next_s = FETCH;
      default: state_next_s = IDLE;
    endcase
  end

  // Architectural PC, latched instruction, trap info and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= 32'h0000_0000;
      trap_cause_r <= 2'd0;
      trap_epc_r   <= 32'h0000_0000;
      retired_r    <= 64'd0;
    end else begin
      case (state_r)
        WAIT_RSP: begin
          if (ifu_rsp_valid && ifu_rsp_err) begin
            trap_cause_r <= CAUSE_FETCH;
            trap_epc_r   <= pc_r;
          end else if (ifu_rsp_valid) begin
            inst_r    <= ifu_rsp_inst;
            inst_pc_r <= pc_r;
          end else begin
            inst_r <= inst_r;
          end
        end
        EXEC: begin
          if (exu_done && misaligned_s) begin
            trap_cause_r <= CAUSE_MISALIGN;
            trap_epc_r   <= inst_pc_r;
          end else if (exu_done) begin
            pc_r      <= pc_new;
            retired_r <= retired_r + 64'd1;
          end else begin
            pc_r <= pc_r;
          end
        end
        TRAP:    pc_r <= {mtvec[31:2], 2'b00};
        default: pc_r <= pc_r;
      endcase
    end
  end

  assign ifu_req_valid = (state_r == FETCH);
  assign ifu_req_addr  = pc_r;
  assign inst_valid    = (state_r == EXEC);
  assign inst          = inst_r;
  assign inst_pc       = inst_pc_r;
  assign pc_pc         = inst_pc_r + 32'd4;
  assign trap_valid    = (state_r == TRAP);
  assign trap_cause    = trap_cause_r;
  assign trap_epc      = trap_epc_r;
  assign retired       = retired_r;

endmodule

// File: tb/tb_ysyx_22040759_pc_ctrl.sv
// Directed bench for ysyx_22040759_pc_ctrl: hand-computed expectations per cycle.
module tb_ysyx_22040759_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_pc;
  logic        exu_jump;
  logic        exu_link;
  logic        exu_done;
  logic        pc_sel;
  logic        wreg_sel;
  logic [31:0] pc_new;
  logic [31:0] mtvec;
  logic        trap_valid;
  logic [1:0]  trap_cause;
  logic [31:0] trap_epc;
  logic [63:0] retired;

  int vectors = 0;
  int miscompares = 0;

  ysyx_22040759_pc_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc_pc(pc_pc),
    .exu_jump(exu_jump), .exu_link(exu_link), .exu_done(exu_done),
    .pc_sel(pc_sel), .wreg_sel(wreg_sel), .pc_new(pc_new), .mtvec(mtvec),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'h0;
    ifu_rsp_err = 1'b0; exu_jump = 1'b0; exu_link = 1'b0; exu_done = 1'b0;
    pc_new = 32'h0; mtvec = 32'h8000_1003;
    tick(); tick();
    chk("rst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("rst_addr", 64'(ifu_req_addr), 64'h8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_trap_valid", 64'(trap_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_trap", 64'({trap_cause, trap_epc}), 64'd0);
    chk("rst_retired", retired, 64'd0);
    chk("rst_sels", 64'({pc_sel, wreg_sel}), 64'd0);
    rst_n = 1'b1;
    chk("idle_req_valid", 64'(ifu_req_valid), 64'd0);

    // Basic sequential instruction, zero-wait everywhere.
    ifu_req_ready = 1'b1;
    tick();
    chk("t1_fetch_valid", 64'(ifu_req_valid), 64'd1);
    chk("t1_fetch_addr", 64'(ifu_req_addr), 64'h8000_0000);
    tick();
    chk("t1_wait_valid", 64'(ifu_req_valid), 64'd0);
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_0013;
    tick();
    chk("t1_inst_valid", 64'(inst_valid), 64'd1);
    chk("t1_inst", 64'(inst), 64'h0000_0013);
    chk("t1_inst_pc", 64'(inst_pc), 64'h8000_0000);
    chk("t1_pc_pc", 64'(pc_pc), 64'h8000_0004);
    chk("t1_sels", 64'({pc_sel, wreg_sel}), 64'd0);
    ifu_rsp_valid = 1'b0; exu_done = 1'b1; pc_new = 32'h8000_0004;
    tick();
    chk("t1_next_addr", 64'(ifu_req_addr), 64'h8000_0004);
    chk("t1_next_valid", 64'(ifu_req_valid), 64'd1);
    chk("t1_retired", retired, 64'd1);
    exu_done = 1'b0;

    // Jump and link.
    tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h1000_006F;
    tick();
    ifu_rsp_valid = 1'b0; exu_jump = 1'b1; exu_link = 1'b1;
    #1;
    chk("t2_pc_sel", 64'(pc_sel), 64'd1);
    chk("t2_wreg_sel", 64'(wreg_sel), 64'd1);
    exu_done = 1'b1; pc_new = 32'h8000_0100;
    tick();
    chk("t2_next_addr", 64'(ifu_req_addr), 64'h8000_0100);
    chk("t2_sels_outside", 64'({pc_sel, wreg_sel}), 64'd0);
    chk("t2_retired", retired, 64'd2);
    exu_done = 1'b0; exu_jump = 1'b0; exu_link = 1'b0;

    // Step to 0x8000_0008, then fetch error there.
    tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_0013;
    tick();
    ifu_rsp_valid = 1'b0; exu_done = 1'b1; pc_new = 32'h8000_0008;
    tick();
    chk("t3_fetch_addr", 64'(ifu_req_addr), 64'h8000_0008);
    exu_done = 1'b0;
    tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_err = 1'b1;
    tick();
    chk("t3_trap_valid", 64'(trap_valid), 64'd1);
    chk("t3_trap_cause", 64'(trap_cause), 64'd1);
    chk("t3_trap_epc", 64'(trap_epc), 64'h8000_0008);
    chk("t3_no_exec", 64'(inst_valid), 64'd0);
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
    tick();
    chk("t3_trap_pulse", 64'(trap_valid), 64'd0);
    chk("t3_redirect", 64'(ifu_req_addr), 64'h8000_1000);
    chk("t3_retired", retired, 64'd3);

    // Misaligned jump target.
    tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0020_0067;
    tick();
    ifu_rsp_valid = 1'b0; exu_jump = 1'b1; exu_done = 1'b1; pc_new = 32'h8000_0102;
    tick();
    chk("t4_trap_valid", 64'(trap_valid), 64'd1);
    chk("t4_trap_cause", 64'(trap_cause), 64'd0);
    chk("t4_trap_epc", 64'(trap_epc), 64'h8000_1000);
    chk("t4_retired", retired, 64'd3);
    exu_done = 1'b0; exu_jump = 1'b0;
    tick();
    chk("t4_redirect", 64'(ifu_req_addr), 64'h8000_1000);

    // Backpressure with spurious response/done pulses.
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hBAD0_0000; exu_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 64'(ifu_req_valid), 64'd1);
      chk("t5_hold_addr", 64'(ifu_req_addr), 64'h8000_1000);
    end
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0;
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_wait_idle", 64'({ifu_req_valid, inst_valid}), 64'd0);
    end
    exu_done = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0010_0093;
    tick();
    chk("t5_inst", 64'(inst), 64'h0010_0093);
    ifu_rsp_inst = 32'hDEAD_BEEF; pc_new = 32'h8000_1004;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_exec_hold", 64'({inst_valid, inst}), {31'd0, 1'b1, 32'h0010_0093});
    end
    ifu_rsp_valid = 1'b0; exu_done = 1'b1;
    tick();
    chk("t5_next_addr", 64'(ifu_req_addr), 64'h8000_1004);
    chk("t5_retired", retired, 64'd4);
    exu_done = 1'b0; ifu_req_ready = 1'b1;

    // Reset pulse while waiting for a response.
    tick();
    chk("t6_in_wait", 64'(ifu_req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", 64'(ifu_req_addr), 64'h8000_0000);
    chk("t6_rst_retired", retired, 64'd0);
    chk("t6_rst_regs", 64'({trap_cause, inst_pc}), 64'd0);
    chk("t6_rst_trap_epc", 64'(trap_epc), 64'd0);
    tick();
    rst_n = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hCAFE_0001;
    tick();
    chk("t6_refetch_valid", 64'(ifu_req_valid), 64'd1);
    chk("t6_refetch_addr", 64'(ifu_req_addr), 64'h8000_0000);
    chk("t6_late_ignored", 64'({inst_valid, inst}), 64'd0);
    ifu_rsp_valid = 1'b0;

    // pc_pc wraps at the top of the address space.
    tick();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_0013;
    tick();
    ifu_rsp_valid = 1'b0; exu_done = 1'b1; pc_new = 32'hFFFF_FFFC;
    tick();
    chk("t7_fetch_top", 64'(ifu_req_addr), 64'hFFFF_FFFC);
    exu_done = 1'b0;
    tick();
    ifu_rsp_valid = 1'b1;
    tick();
    chk("t7_inst_pc", 64'(inst_pc), 64'hFFFF_FFFC);
    chk("t7_pc_pc_wrap", 64'(pc_pc), 64'd0);
    ifu_rsp_valid = 1'b0; exu_done = 1'b1; pc_new = 32'h0000_0000;
    tick();
    chk("t7_fetch_zero", 64'(ifu_req_addr), 64'd0);
    chk("t7_retired", retired, 64'd2);
    exu_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
